sal_refresh_sched: RTL and testbench

Per-rank DDR2 auto-refresh scheduler inside the controller, between the timing counters and the command arbiter that drives the DFI control interface.
- Tracks owed refreshes (debt) for each rank.
- Issues refreshes opportunistically when a rank is idle.
- Escalates to urgent when the postpone limit is reached.
- Blocks new ACTs to a rank while it is urgent or inside tRFC.
- Arbitrates between ranks round-robin: one REF command in flight per handshake.

---
 rtl/sal_refresh_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_sal_refresh_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_refresh_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sal_refresh_sched
// Brief    : Per-rank DDR2 auto-refresh scheduler. Tracks the refresh debt of
//            each rank and issues refreshes while a rank is idle. A rank that
//            reaches the postpone limit escalates to urgent. New ACTs to a rank
//            are blocked while it is urgent or inside tRFC. Ranks are picked
//            round-robin, with at most one REF request outstanding.
// Options  : SAL_REF_PERF_CNT_EN adds the ref_cnt_o / urgent_cnt_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module sal_refresh_sched #(
    parameter int NUM_RANKS    = 2,
    parameter int TREFI_CYCLES = 1560,
    parameter int TRFC_CYCLES  = 26,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_done_i,
    input  logic [NUM_RANKS-1:0]         rank_idle_i,
    output logic                         ref_req_o,
    output logic [$clog2(NUM_RANKS)-1:0] ref_rank_o,
    output logic                         ref_urgent_o,
    input  logic                         ref_gnt_i,
    output logic [NUM_RANKS-1:0]         rank_block_o,
    output logic                         err_o
`ifdef SAL_REF_PERF_CNT_EN
    ,
    output logic [31:0]                  ref_cnt_o,
    output logic [15:0]                  urgent_cnt_o
`endif
);

    localparam int c_RANK_W = $clog2(NUM_RANKS);
    localparam int c_IV_W   = $clog2(TREFI_CYCLES);
    localparam int c_RFC_W  = $clog2(TRFC_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_RANK_W-1:0]    r_rank;
    logic                   r_urgent;
    logic [c_RANK_W-1:0]    r_rr_ptr;
    logic                   r_err;
    logic [NUM_RANKS-1:0]   r_block;

    logic [c_IV_W-1:0]      r_iv_cnt [NUM_RANKS];
    logic [3:0]             r_debt   [NUM_RANKS];
    logic [c_RFC_W-1:0]     r_trfc   [NUM_RANKS];

    logic [NUM_RANKS-1:0]   w_tick;
    logic [NUM_RANKS-1:0]   w_gnt_rank;
    logic [NUM_RANKS-1:0]   w_urgent;
    logic [NUM_RANKS-1:0]   w_elig;
    logic [NUM_RANKS-1:0]   w_ovf;
    logic [NUM_RANKS-1:0]   w_block_nxt;
    logic                   w_gnt;
    logic                   w_sel_found;
    logic [c_RANK_W-1:0]    w_sel_rank;
    logic                   w_sel_urg;

    // A grant only counts while a request is actually outstanding.
    assign w_gnt = (r_state == ST_REQ) && ref_gnt_i;

    // Rank visited at position 'off' of the round-robin walk starting after 'ptr'.
    function automatic logic [c_RANK_W-1:0] rr_idx(input logic [c_RANK_W-1:0] ptr,
                                                   input int off);
        return c_RANK_W'((int'(ptr) + off) % NUM_RANKS);
    endfunction

    // Per-rank interval, debt and tRFC tracking.
    for (genvar g = 0; g < NUM_RANKS; g++) begin : g_rank
        // Staggered start so that the ranks do not all come due together.
        localparam int c_IV_LOAD = TREFI_CYCLES - 1 - g * (TREFI_CYCLES / NUM_RANKS);

        logic [3:0]         w_debt_nxt;
        logic [c_RFC_W-1:0] w_trfc_nxt;

        assign w_tick[g]     = init_done_i && (r_iv_cnt[g] == '0);
        assign w_gnt_rank[g] = w_gnt && (r_rank == c_RANK_W'(g));
        assign w_urgent[g]   = (r_debt[g] >= 4'(MAX_POSTPONE));
        assign w_elig[g]     = (r_debt[g] != 4'd0) && (r_trfc[g] == '0) &&
                               (rank_idle_i[g] || w_urgent[g]) && init_done_i;
        assign w_ovf[g]      = w_tick[g] && (r_debt[g] == 4'hF);

        // Debt update: a tick owes one more refresh, a grant pays one off.
        always_comb begin
            w_debt_nxt = r_debt[g];
            case ({w_tick[g], w_gnt_rank[g]})
                2'b10:   w_debt_nxt = (r_debt[g] == 4'hF) ? 4'hF : r_debt[g] + 4'd1;
                2'b01:   w_debt_nxt = (r_debt[g] == 4'd0) ? 4'd0 : r_debt[g] - 4'd1;
                default: w_debt_nxt = r_debt[g];
            endcase
        end

        // tRFC window is opened by a grant and counts down to zero.
        always_comb begin
            w_trfc_nxt = r_trfc[g];
            if (w_gnt_rank[g]) begin
                w_trfc_nxt = c_RFC_W'(TRFC_CYCLES);
            end else if (r_trfc[g] != '0) begin
                w_trfc_nxt = r_trfc[g] - c_RFC_W'(1);
            end
        end

        // Block is derived from next-state values so it shows one cycle after its cause.
        assign w_block_nxt[g] = (w_debt_nxt >= 4'(MAX_POSTPONE)) || (w_trfc_nxt != '0);

        // Refresh interval counter: counts only once DRAM init has finished.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                r_iv_cnt[g] <= c_IV_W'(c_IV_LOAD);
            end else if (init_done_i) begin
                if (r_iv_cnt[g] == '0) begin
                    r_iv_cnt[g] <= c_IV_W'(TREFI_CYCLES - 1);
                end else begin
                    r_iv_cnt[g] <= r_iv_cnt[g] - c_IV_W'(1);
                end
            end
        end

        // Debt and tRFC state registers.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                r_debt[g] <= 4'd0;
                r_trfc[g] <= '0;
            end else begin
                r_debt[g] <= w_debt_nxt;
                r_trfc[g] <= w_trfc_nxt;
            end
        end
    end

    // Pick the next rank: urgent ranks first, then round-robin after the last grant.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_rank  = '0;
        w_sel_urg   = 1'b0;
        for (int i = 1; i <= NUM_RANKS; i++) begin
            if (!w_sel_found && w_elig[rr_idx(r_rr_ptr, i)] && w_urgent[rr_idx(r_rr_ptr, i)]) begin
                w_sel_found = 1'b1;
                w_sel_rank  = rr_idx(r_rr_ptr, i);
                w_sel_urg   = 1'b1;
            end
        end
        for (int i = 1; i <= NUM_RANKS; i++) begin
            if (!w_sel_found && w_elig[rr_idx(r_rr_ptr, i)]) begin
                w_sel_found = 1'b1;
                w_sel_rank  = rr_idx(r_rr_ptr, i);
                w_sel_urg   = w_urgent[rr_idx(r_rr_ptr, i)];
            end
        end
    end

    // Next-state logic: a request is held until it is granted, never withdrawn.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_sel_found) w_state_nxt = ST_REQ;
            ST_REQ:  if (ref_gnt_i)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the target at request entry; move the round-robin pointer on grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rank   <= '0;
            r_urgent <= 1'b0;
            r_rr_ptr <= c_RANK_W'(NUM_RANKS - 1);
        end else begin
            if ((r_state == ST_IDLE) && w_sel_found) begin
                r_rank   <= w_sel_rank;
                r_urgent <= w_sel_urg;
            end
            if (w_gnt) begin
                r_rr_ptr <= r_rank;
            end
        end
    end

    // ACT-block flags and the sticky debt-overflow error.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_block <= '0;
            r_err   <= 1'b0;
        end else begin
            r_block <= w_block_nxt;
            r_err   <= r_err | (|w_ovf);
        end
    end

    assign ref_req_o    = (r_state == ST_REQ);
    assign ref_rank_o   = r_rank;
    assign ref_urgent_o = r_urgent && (r_state == ST_REQ);
    assign rank_block_o = r_block;
    assign err_o        = r_err;

`ifdef SAL_REF_PERF_CNT_EN
    logic [31:0] r_ref_cnt;
    logic [15:0] r_urgent_cnt;

    // Grant counters; they wrap naturally at their maximum value.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_ref_cnt    <= 32'd0;
            r_urgent_cnt <= 16'd0;
        end else if (w_gnt) begin
            r_ref_cnt <= r_ref_cnt + 32'd1;
            if (r_urgent) begin
                r_urgent_cnt <= r_urgent_cnt + 16'd1;
            end
        end
    end

    assign ref_cnt_o    = r_ref_cnt;
    assign urgent_cnt_o = r_urgent_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sal_refresh_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sal_refresh_sched
// Brief    : Scoreboard bench for sal_refresh_sched (TREFI=100, TRFC=10,
//            MAX_POSTPONE=4, 2 ranks). Stimulus pushes the expected requests
//            and a monitor pops and compares them whenever a request rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sal_refresh_sched;

    logic       clk;
    logic       rst_n;
    logic       init_done_i;
    logic [1:0] rank_idle_i;
    logic       ref_req_o;
    logic [0:0] ref_rank_o;
    logic       ref_urgent_o;
    logic       ref_gnt_i;
    logic [1:0] rank_block_o;
    logic       err_o;
`ifdef SAL_REF_PERF_CNT_EN
    logic [31:0] ref_cnt_o;
    logic [15:0] urgent_cnt_o;
`endif

    sal_refresh_sched #(
        .NUM_RANKS   (2),
        .TREFI_CYCLES(100),
        .TRFC_CYCLES (10),
        .MAX_POSTPONE(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done_i (init_done_i),
        .rank_idle_i (rank_idle_i),
        .ref_req_o   (ref_req_o),
        .ref_rank_o  (ref_rank_o),
        .ref_urgent_o(ref_urgent_o),
        .ref_gnt_i   (ref_gnt_i),
        .rank_block_o(rank_block_o),
        .err_o       (err_o)
`ifdef SAL_REF_PERF_CNT_EN
        ,
        .ref_cnt_o   (ref_cnt_o),
        .urgent_cnt_o(urgent_cnt_o)
`endif
    );

    typedef struct {
        int rank;
        int urg;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_chk;
    int   cyc;
    int   base;
    bit   gnt_en;
    bit   stray;
    bit   chk_block;
    int   gnt_delay;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int rank, input int urg, input int c);
        exp_t e;
        e.rank = rank;
        e.urg  = urg;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        init_done_i = 1'b1;
        base        = cyc;
    endtask

    // Arbiter model: grants gnt_delay cycles after a request is seen, one-cycle pulse.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        ref_gnt_i = 1'b0;
        forever begin
            @(negedge clk);
            if (ref_gnt_i) begin
                ref_gnt_i = 1'b0;
            end else if (stray) begin
                ref_gnt_i = 1'b1;
                stray     = 1'b0;
            end else if (ref_req_o && gnt_en) begin
                if (wait_cnt >= gnt_delay) begin
                    ref_gnt_i = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Request monitor: pops expectations on each new request, checks hold stability.
    initial begin
        bit   prev_req;
        bit   unstable;
        int   h_rank;
        int   h_urg;
        exp_t e;
        prev_req = 1'b0;
        unstable = 1'b0;
        h_rank   = 0;
        h_urg    = 0;
        forever begin
            @(negedge clk);
            if (ref_req_o && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_rank", ref_rank_o, e.rank);
                    check("req_urgent", ref_urgent_o, e.urg);
                    check("req_cycle", cyc - base, e.cyc - base);
                end
                h_rank   = ref_rank_o;
                h_urg    = ref_urgent_o;
                unstable = 1'b0;
            end else if (ref_req_o && prev_req) begin
                if (ref_rank_o != h_rank || ref_urgent_o != h_urg) unstable = 1'b1;
            end else if (!ref_req_o && prev_req) begin
                check("req_stable", unstable, 0);
            end
            prev_req = ref_req_o;
        end
    end

    // ACT-block monitor: every tRFC-only block window must last exactly 10 cycles.
    initial begin
        int run[2];
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!chk_block) begin
                    run[r] = 0;
                end else if (rank_block_o[r]) begin
                    run[r]++;
                end else if (run[r] > 0) begin
                    check("block_len", run[r], 10);
                    run[r] = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass      = 0;
        n_chk       = 0;
        base        = 0;
        gnt_en      = 1'b0;
        stray       = 1'b0;
        chk_block   = 1'b0;
        gnt_delay   = 0;
        init_done_i = 1'b0;
        rank_idle_i = 2'b00;
        rst_n       = 1'b0;
        #1;
        rst_n = 1'b1;
        #2;
        check("rst_req", ref_req_o, 0);
        check("rst_rank", ref_rank_o, 0);
        check("rst_urgent", ref_urgent_o, 0);
        check("rst_block", rank_block_o, 0);
        check("rst_err", err_o, 0);

        // Test 1: idle ranks, grant one cycle after request.
        rank_idle_i = 2'b11;
        gnt_en      = 1'b1;
        gnt_delay   = 1;
        chk_block   = 1'b1;
        do_reset();
        push(1, 0, base + 51);
        push(0, 0, base + 101);
        push(1, 0, base + 151);
        at(base + 170);
        stray = 1'b1;
        at(base + 175);
        check("t1_debt0", dut.r_debt[0], 0);
        check("t1_debt1", dut.r_debt[1], 0);
        check("t1_q_empty", exp_q.size(), 0);
        chk_block = 1'b0;

        // Test 2: busy ranks escalate to urgent; grant withheld then released.
        rank_idle_i = 2'b00;
        gnt_en      = 1'b0;
        gnt_delay   = 0;
        do_reset();
        push(1, 1, base + 351);
        at(base + 345);
        check("t2_block_pre", rank_block_o, 2'b00);
        at(base + 351);
        check("t2_block_r1", rank_block_o, 2'b10);
        at(base + 420);
        check("t2_block_both", rank_block_o, 2'b11);
        check("t2_req_held", ref_req_o, 1);
        check("t2_rank_held", ref_rank_o, 1);
        push(0, 1, base + 422);
        gnt_en = 1'b1;
        at(base + 430);
        check("t2_q_empty", exp_q.size(), 0);
`ifdef SAL_REF_PERF_CNT_EN
        check("t2_ref_cnt", ref_cnt_o, 2);
        check("t2_urgent_cnt", urgent_cnt_o, 2);
`endif

        // Test 3: both ranks owe 2, alternating grants with tRFC skipping.
        rank_idle_i = 2'b00;
        gnt_en      = 1'b0;
        gnt_delay   = 0;
        do_reset();
        push(0, 0, base + 201);
        push(1, 0, base + 203);
        push(0, 0, base + 213);
        push(1, 0, base + 215);
        at(base + 200);
        rank_idle_i = 2'b11;
        gnt_en      = 1'b1;
        at(base + 230);
        check("t3_debt0", dut.r_debt[0], 0);
        check("t3_debt1", dut.r_debt[1], 0);
        check("t3_q_empty", exp_q.size(), 0);
`ifdef SAL_REF_PERF_CNT_EN
        check("t3_ref_cnt", ref_cnt_o, 4);
        check("t3_urgent_cnt", urgent_cnt_o, 0);
`endif

        // Test 4: grant to rank1 lands on the same edge as its interval tick.
        rank_idle_i = 2'b00;
        gnt_en      = 1'b1;
        gnt_delay   = 88;
        do_reset();
        at(base + 60);
        push(1, 0, base + 61);
        rank_idle_i = 2'b10;
        at(base + 150);
        check("t4_debt1_same", dut.r_debt[1], 1);
        push(1, 0, base + 161);
        at(base + 165);
        check("t4_q_empty", exp_q.size(), 0);

        // Test 5: never grant; debt saturates and overflow sets sticky err_o.
        rank_idle_i = 2'b00;
        gnt_en      = 1'b0;
        gnt_delay   = 0;
        do_reset();
        push(1, 1, base + 351);
        at(base + 1505);
        check("t5_debt0_sat", dut.r_debt[0], 15);
        check("t5_err_pre", err_o, 0);
        at(base + 1545);
        check("t5_err_still0", err_o, 0);
        at(base + 1555);
        check("t5_err_set", err_o, 1);
        at(base + 1620);
        check("t5_err_sticky", err_o, 1);
        check("t5_debt0_hold", dut.r_debt[0], 15);
        check("t5_q_empty", exp_q.size(), 0);

        // Test 6: reset during REQ drops the request immediately.
        rst_n = 1'b1;
        #1;
        check("t6_req_async", ref_req_o, 0);
        check("t6_err_clr", err_o, 0);
        check("t6_block_clr", rank_block_o, 0);
        init_done_i = 1'b0;
        rank_idle_i = 2'b11;
        gnt_en      = 1'b1;
        gnt_delay   = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
`ifdef SAL_REF_PERF_CNT_EN
        check("t6_ref_cnt_rst", ref_cnt_o, 0);
`endif
        repeat (20) @(posedge clk);
        #1;
        init_done_i = 1'b1;
        base        = cyc;
        push(1, 0, base + 51);
        at(base + 60);
        check("t6_q_empty", exp_q.size(), 0);
`ifdef SAL_REF_PERF_CNT_EN
        check("t6_ref_cnt", ref_cnt_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
